// File: rtl/coef_loader_7tap_if.sv
// Coefficient stream interface between the host and coef_loader_7tap.
//
// Handshake: a beat transfers on a rising clk edge where s_coef_valid and
// s_coef_ready are both high. The master holds s_coef_data and s_coef_last
// stable while s_coef_valid is high and s_coef_ready is low; the slave may
// raise or drop s_coef_ready at any time, independent of s_coef_valid.
interface coef_loader_7tap_if;
  logic signed [7:0] s_coef_data;
  logic              s_coef_valid;
  logic              s_coef_last;
  logic              s_coef_ready;

  modport master (
    output s_coef_data,
    output s_coef_valid,
    output s_coef_last,
    input  s_coef_ready
  );

  modport slave (
    input  s_coef_data,
    input  s_coef_valid,
    input  s_coef_last,
    output s_coef_ready
  );
endinterface

// File: rtl/coef_loader_7tap.sv
// Coefficient loader for a 7-tap filter.
// Collects a 7-beat coefficient set from the host stream, then writes it to
// the filter as a 7-cycle burst (writeen/coef_val, tlast on the last tap).
// Short sets, overlong sets and illegal values are rejected without any
// filter write; overlong or illegal sets are drained up to their last beat.
// Optional build macro: COEF_SPARSE_CHECK_EN -- when defined, only the
// values -1, 0 and +1 are legal coefficients.
// fsm_state exposes the current FSM state for observation.
module coef_loader_7tap (
  input  logic              clk,
  input  logic              rst,
  coef_loader_7tap_if.slave s,
  output logic signed [7:0] coef_val,
  output logic              writeen,
  output logic              tlast,
  output logic              load_done,
  output logic              load_err,
  output logic [2:0]        nz_count,
  output logic [2:0]        fsm_state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    PUSH    = 3'd2,
    DRAIN   = 3'd3,
    DONE    = 3'd4,
    ERR     = 3'd5
  } state_t;

  state_t            state, state_nx;
  logic [2:0]        cnt, cnt_nx;      // beat index while collecting, tap index while pushing
  logic signed [7:0] coef_buf [0:6];
  logic              ready_en;         // keeps ready low until the first edge after reset
  logic              accept;
  logic              store;
  logic              illegal;
  logic [2:0]        nz_nx;

  assign fsm_state = state;

  assign s.s_coef_ready = ready_en &&
                          (state == IDLE || state == COLLECT || state == DRAIN);
  assign accept = s.s_coef_valid && s.s_coef_ready;

`ifdef COEF_SPARSE_CHECK_EN
  assign illegal = !((s.s_coef_data == 8'sd0) ||
                     (s.s_coef_data == 8'sd1) ||
                     (s.s_coef_data == -8'sd1));
`else
  assign illegal = 1'b0;
`endif

  // Next-state, beat/tap counter and filter-side outputs.
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    store     = 1'b0;
    coef_val  = 8'sd0;
    writeen   = 1'b0;
    tlast     = 1'b0;
    load_done = 1'b0;
    load_err  = 1'b0;
    case (state)
      IDLE, COLLECT: begin
        if (accept) begin
          store = 1'b1;
          if (s.s_coef_last) begin
            cnt_nx   = 3'd0;
            state_nx = (cnt == 3'd6 && !illegal) ? PUSH : ERR;
          end else if (cnt == 3'd6 || illegal) begin
            cnt_nx   = 3'd0;
            state_nx = DRAIN;
          end else begin
            cnt_nx   = cnt + 3'd1;
            state_nx = COLLECT;
          end
        end
      end
      PUSH: begin
        writeen  = 1'b1;
        coef_val = coef_buf[cnt];
        tlast    = (cnt == 3'd6);
        if (cnt == 3'd6) begin
          cnt_nx   = 3'd0;
          state_nx = DONE;
        end else begin
          cnt_nx = cnt + 3'd1;
        end
      end
      DRAIN: begin
        if (accept && s.s_coef_last) state_nx = ERR;
      end
      DONE: begin
        load_done = 1'b1;
        state_nx  = IDLE;
      end
      ERR: begin
        load_err = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Number of nonzero taps in the buffered set.
  always_comb begin
    nz_nx = 3'd0;
    for (int i = 0; i < 7; i++) begin
      if (coef_buf[i] != 8'sd0) nz_nx = nz_nx + 3'd1;
    end
  end

  // State, counter, ready enable and nonzero-tap count registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= 3'd0;
      ready_en <= 1'b0;
      nz_count <= 3'd0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      ready_en <= 1'b1;
      if (state == PUSH && state_nx == DONE) nz_count <= nz_nx;
    end
  end

  // Coefficient buffer, written in arrival order while collecting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 7; i++) coef_buf[i] <= 8'sd0;
    end else if (store) begin
      coef_buf[cnt] <= s.s_coef_data;
    end
  end

endmodule

// File: tb/tb_coef_loader_7tap.sv
// Directed testbench for coef_loader_7tap.
module tb_coef_loader_7tap;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_DRAIN = 3'd3;

  logic       clk;
  logic       rst;
  logic [7:0] coef_val;
  logic       writeen;
  logic       tlast;
  logic       load_done;
  logic       load_err;
  logic [2:0] nz_count;
  logic [2:0] fsm_state;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int write_cnt = 0;
  int done_cnt  = 0;
  int err_cnt   = 0;

  logic [7:0] exp_q [$];
  logic [7:0] good_vals [7];
  logic [7:0] ill_vals  [7];
  logic [7:0] rst_vals  [7];

  coef_loader_7tap_if bus ();

  coef_loader_7tap dut (
    .clk       (clk),
    .rst       (rst),
    .s         (bus.slave),
    .coef_val  (coef_val),
    .writeen   (writeen),
    .tlast     (tlast),
    .load_done (load_done),
    .load_err  (load_err),
    .nz_count  (nz_count),
    .fsm_state (fsm_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    rst = 1'b0;
    bus.s_coef_valid = 1'b0;
    bus.s_coef_last  = 1'b0;
    bus.s_coef_data  = 8'sd0;
  end

  // Strobe counters observed on the falling edge
  always @(negedge clk) begin
    if (writeen)   write_cnt++;
    if (load_done) done_cnt++;
    if (load_err)  err_cnt++;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Driver: present one beat, wait (bounded) for ready, transfer it.
  task automatic send_beat(input logic [7:0] d, input logic l);
    int guard = 0;
    bus.s_coef_valid = 1'b1;
    bus.s_coef_data  = d;
    bus.s_coef_last  = l;
    while (!bus.s_coef_ready && guard < 20) begin
      step();
      guard++;
    end
    total_cnt++;
    if (bus.s_coef_ready !== 1'b1) $display("FAIL beat_ready: ready=%b required 1", bus.s_coef_ready);
    else pass_cnt++;
    step();
    bus.s_coef_valid = 1'b0;
    bus.s_coef_last  = 1'b0;
    bus.s_coef_data  = 8'sd0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if (fsm_state !== ST_IDLE) $display("FAIL rst_state: got %0d required %0d", fsm_state, ST_IDLE);
    else pass_cnt++;
    total_cnt++;
    if ({bus.s_coef_ready, writeen, tlast, load_done, load_err} !== 5'b0)
      $display("FAIL rst_strobes: got %b required 00000",
               {bus.s_coef_ready, writeen, tlast, load_done, load_err});
    else pass_cnt++;
    total_cnt++;
    if ({coef_val, nz_count} !== 11'd0) $display("FAIL rst_values: coef_val=%h nz=%0d required 0", coef_val, nz_count);
    else pass_cnt++;
    rst = 1'b1;
    #1;
    total_cnt++;
    if (bus.s_coef_ready !== 1'b0) $display("FAIL rst_ready_before_edge: got %b required 0", bus.s_coef_ready);
    else pass_cnt++;
    step();
    total_cnt++;
    if (bus.s_coef_ready !== 1'b1) $display("FAIL rst_ready_after_edge: got %b required 1", bus.s_coef_ready);
    else pass_cnt++;
  endtask

  // Sends a legal 7-beat set and checks the full write burst and completion.
  task automatic run_good(input logic [7:0] vals [7], input logic [2:0] exp_nz, input string tag);
    logic [7:0] exp_v;
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back(vals[i]);
      send_beat(vals[i], i == 6);
    end
    for (int k = 0; k < 7; k++) begin
      exp_v = exp_q.pop_front();
      total_cnt++;
      if (writeen !== 1'b1 || tlast !== (k == 6) || bus.s_coef_ready !== 1'b0)
        $display("FAIL %s_push_ctl[%0d]: writeen=%b tlast=%b ready=%b required 1 %b 0",
                 tag, k, writeen, tlast, bus.s_coef_ready, (k == 6));
      else pass_cnt++;
      total_cnt++;
      if (coef_val !== exp_v) $display("FAIL %s_coef[%0d]: got %h required %h", tag, k, coef_val, exp_v);
      else pass_cnt++;
      step();
    end
    total_cnt++;
    if (load_done !== 1'b1 || writeen !== 1'b0 || load_err !== 1'b0)
      $display("FAIL %s_done: load_done=%b writeen=%b load_err=%b required 1 0 0", tag, load_done, writeen, load_err);
    else pass_cnt++;
    step();
    total_cnt++;
    if (bus.s_coef_ready !== 1'b1 || load_done !== 1'b0)
      $display("FAIL %s_ready_back: ready=%b load_done=%b required 1 0", tag, bus.s_coef_ready, load_done);
    else pass_cnt++;
    total_cnt++;
    if (nz_count !== exp_nz) $display("FAIL %s_nz: got %0d required %0d", tag, nz_count, exp_nz);
    else pass_cnt++;
  endtask

  task automatic test_good_set();
    run_good(good_vals, 3'd4, "good");
  endtask

  task automatic test_short_set();
    int w0 = write_cnt;
    int e0 = err_cnt;
    for (int i = 0; i < 5; i++) send_beat((i % 2 == 0) ? 8'h01 : 8'h00, i == 4);
    total_cnt++;
    if (load_err !== 1'b1 || bus.s_coef_ready !== 1'b0)
      $display("FAIL short_err: load_err=%b ready=%b required 1 0", load_err, bus.s_coef_ready);
    else pass_cnt++;
    step();
    total_cnt++;
    if (bus.s_coef_ready !== 1'b1 || load_err !== 1'b0)
      $display("FAIL short_ready_back: ready=%b load_err=%b required 1 0", bus.s_coef_ready, load_err);
    else pass_cnt++;
    total_cnt++;
    if (write_cnt !== w0 || err_cnt !== e0 + 1)
      $display("FAIL short_counts: writes=%0d errs=%0d required %0d %0d", write_cnt - w0, err_cnt - e0, 0, 1);
    else pass_cnt++;
    total_cnt++;
    if (nz_count !== 3'd4) $display("FAIL short_nz_hold: got %0d required 4", nz_count);
    else pass_cnt++;
  endtask

  task automatic test_overflow();
    int w0 = write_cnt;
    int e0 = err_cnt;
    for (int i = 0; i < 9; i++) begin
      send_beat(8'h01, i == 8);
      if (i == 6) begin
        total_cnt++;
        if (fsm_state !== ST_DRAIN || bus.s_coef_ready !== 1'b1)
          $display("FAIL ovf_drain: state=%0d ready=%b required %0d 1", fsm_state, bus.s_coef_ready, ST_DRAIN);
        else pass_cnt++;
      end
      if (i == 7) begin
        total_cnt++;
        if (load_err !== 1'b0) $display("FAIL ovf_early_err: load_err=%b required 0", load_err);
        else pass_cnt++;
      end
    end
    total_cnt++;
    if (load_err !== 1'b1) $display("FAIL ovf_err: load_err=%b required 1", load_err);
    else pass_cnt++;
    step();
    total_cnt++;
    if (write_cnt !== w0 || err_cnt !== e0 + 1 || bus.s_coef_ready !== 1'b1)
      $display("FAIL ovf_counts: writes=%0d errs=%0d ready=%b required 0 1 1", write_cnt - w0, err_cnt - e0, bus.s_coef_ready);
    else pass_cnt++;
  endtask

  task automatic test_illegal_value();
`ifdef COEF_SPARSE_CHECK_EN
    int w0 = write_cnt;
    for (int i = 0; i < 7; i++) begin
      send_beat(ill_vals[i], i == 6);
      if (i == 2) begin
        total_cnt++;
        if (fsm_state !== ST_DRAIN) $display("FAIL ill_drain: state=%0d required %0d", fsm_state, ST_DRAIN);
        else pass_cnt++;
      end
    end
    total_cnt++;
    if (load_err !== 1'b1) $display("FAIL ill_err: load_err=%b required 1", load_err);
    else pass_cnt++;
    step();
    total_cnt++;
    if (write_cnt !== w0 || bus.s_coef_ready !== 1'b1)
      $display("FAIL ill_no_write: writes=%0d ready=%b required 0 1", write_cnt - w0, bus.s_coef_ready);
    else pass_cnt++;
`else
    run_good(ill_vals, 3'd5, "ill");
`endif
  endtask

  task automatic test_reset_during_push();
    int w0;
    int d0;
    for (int i = 0; i < 7; i++) send_beat(rst_vals[i], i == 6);
    step();
    step();
    total_cnt++;
    if (writeen !== 1'b1 || coef_val !== rst_vals[2])
      $display("FAIL rpush_third: writeen=%b coef=%h required 1 %h", writeen, coef_val, rst_vals[2]);
    else pass_cnt++;
    w0 = write_cnt;
    d0 = done_cnt;
    rst = 1'b0;
    #1;
    total_cnt++;
    if (writeen !== 1'b0 || tlast !== 1'b0 || coef_val !== 8'h00)
      $display("FAIL rpush_abort: writeen=%b tlast=%b coef=%h required 0 0 00", writeen, tlast, coef_val);
    else pass_cnt++;
    total_cnt++;
    if (fsm_state !== ST_IDLE || bus.s_coef_ready !== 1'b0 || nz_count !== 3'd0)
      $display("FAIL rpush_state: state=%0d ready=%b nz=%0d required 0 0 0", fsm_state, bus.s_coef_ready, nz_count);
    else pass_cnt++;
    repeat (3) step();
    rst = 1'b1;
    #1;
    total_cnt++;
    if (bus.s_coef_ready !== 1'b0) $display("FAIL rpush_ready_before_edge: got %b required 0", bus.s_coef_ready);
    else pass_cnt++;
    step();
    total_cnt++;
    if (bus.s_coef_ready !== 1'b1) $display("FAIL rpush_ready_after_edge: got %b required 1", bus.s_coef_ready);
    else pass_cnt++;
    total_cnt++;
    if (write_cnt !== w0 || done_cnt !== d0)
      $display("FAIL rpush_no_more: writes=%0d dones=%0d required 0 0", write_cnt - w0, done_cnt - d0);
    else pass_cnt++;
    run_good(good_vals, 3'd4, "after_rst");
  endtask

  initial begin
    good_vals = '{8'h01, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h01, 8'hFF};
    ill_vals  = '{8'h01, 8'h01, 8'h05, 8'h00, 8'h00, 8'h01, 8'hFF};
    rst_vals  = '{8'h01, 8'hFF, 8'h01, 8'h01, 8'h00, 8'h00, 8'h01};
    test_reset();
    test_good_set();
    test_short_set();
    test_overflow();
    test_illegal_value();
    test_reset_during_push();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
